// File: rtl/refresh_sched.sv
// Periodic refresh sequencer: copies the due physical row into the spare row, then pulses any_ref_done.
// Urgent preemption of user traffic is compiled in only when REF_URGENT_EN is defined.
module refresh_sched #(
  parameter int unsigned REF_PERIOD = 64,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned URGENT_LIM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic [2:0]        mem_raddr,
  output logic              mem_we,
  output logic [2:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ref_busy,
  output logic              user_stall,
  output logic              any_ref_done,
  output logic              ref_overrun
);

  localparam int unsigned CNT_W = $clog2(REF_PERIOD);
  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  if (REF_PERIOD < 8 || MEM_LAT < 1 || URGENT_LIM < 1) begin : g_param_check
    $error("refresh_sched: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_LAT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [2:0]        shadow_q [8];
  logic [2:0]        shadow_d [8];
  logic [2:0]        swap_idx_q, swap_idx_d;

  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        raddr_q, raddr_d;
  logic [2:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic tick;
  logic grant;
  logic urgent_go;

  assign tick  = (tick_cnt_q == CNT_W'(REF_PERIOD - 1));
  assign grant = (state_q == S_WAIT) && (!user_req || urgent_go);

  // A tick coinciding with the grant re-arms pending and is not an overrun.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pending_d  = tick | (pending_q & ~grant);
    overrun_d  = overrun_q | (tick & pending_q & ~grant);
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      S_IDLE:  if (pending_q || tick) state_d = S_WAIT;
      S_WAIT:  if (grant) state_d = S_READ;
      S_READ: begin
        state_d   = S_LAT;
        lat_cnt_d = '0;
      end
      S_LAT: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT - 1)) state_d = S_WRITE;
        else lat_cnt_d = lat_cnt_q + 1'b1;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = (pending_q || tick) ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d   = shadow_q;
    swap_idx_d = swap_idx_q;
    if (state_q == S_DONE) begin
      shadow_d[0]          = shadow_q[swap_idx_q];
      shadow_d[swap_idx_q] = shadow_q[0];
      swap_idx_d           = (swap_idx_q == 3'd1) ? 3'd7 : swap_idx_q - 3'd1;
    end
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    re_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    busy_d  = state_d inside {S_READ, S_LAT, S_WRITE, S_DONE};
    done_d  = (state_d == S_DONE);
    raddr_d = re_d ? shadow_q[swap_idx_q] : raddr_q;
    waddr_d = we_d ? shadow_q[0] : waddr_q;
    wdata_d = (state_q == S_LAT && we_d) ? mem_rdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      lat_cnt_q  <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      swap_idx_q <= 3'd1;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow_q[i] <= (i == 0) ? 3'd1 : (i == 1) ? 3'd0 : 3'(i);
      end
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      swap_idx_q <= swap_idx_d;
      shadow_q   <= shadow_d;
      re_q       <= re_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef REF_URGENT_EN
  localparam int unsigned WAIT_W = $clog2(URGENT_LIM + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              stall_q, stall_d;

  assign urgent_go = (wait_cnt_q == WAIT_W'(URGENT_LIM));

  // Stall latches on reaching the limit in WAIT and rides through to DONE.
  always_comb begin
    wait_cnt_d = '0;
    stall_d    = 1'b0;
    if (state_q == S_WAIT && state_d == S_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
    if (state_d == S_WAIT) stall_d = (wait_cnt_d == WAIT_W'(URGENT_LIM));
    else if (state_d inside {S_READ, S_LAT, S_WRITE, S_DONE}) stall_d = stall_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign user_stall = stall_q;
`else
  assign urgent_go  = 1'b0;
  assign user_stall = 1'b0;
`endif

  assign mem_re       = re_q;
  assign mem_raddr    = raddr_q;
  assign mem_we       = we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign ref_busy     = busy_q;
  assign any_ref_done = done_q;
  assign ref_overrun  = overrun_q;

endmodule

// File: doc/refresh_sched.md
# refresh_sched

Periodic refresh sequencer for the GC-DRAM controller with advanced refresh, sitting directly upstream of the shift address table. On each refresh tick it copies the physical row due for refresh into the current spare row, then pulses `any_ref_done` so the address table swaps its mapping. It keeps a shadow copy of the address table so it can issue physical row addresses itself. It yields to user traffic, except when the urgent-preempt option is compiled in.

## Interface
- `REF_PERIOD`, 64: cycles between refresh ticks; must be ≥ 8.
- `MEM_LAT`, 1: array read latency in cycles, ≥ 1.
- `DATA_W`, 8: row data width.
- `URGENT_LIM`, 16: wait cycles before preempting users (used only with `REF_URGENT_EN`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `user_req`  in  1  user access wants the array this cycle.
- `mem_rdata`  in  `DATA_W`  array read data, valid `MEM_LAT` cycles after `mem_re`.
- `mem_re`  out  1  refresh read strobe.
- `mem_raddr`  out  3  physical row to read.
- `mem_we`  out  1  refresh write strobe.
- `mem_waddr`  out  3  physical row to write.
- `mem_wdata`  out  `DATA_W`  captured row data.
- `ref_busy`  out  1  refresh owns the array.
- `user_stall`  out  1  user requests must hold off.
- `any_ref_done`  out  1  one-cycle pulse to the address table.
- `ref_overrun`  out  1  sticky flag: a tick arrived while a refresh was still pending.

## Operation
- Reset (`rst`=0):
  - Shadow table = {1,0,2,3,4,5,6,7}; `swap_idx` = 1; tick counter = 0; pending = 0; FSM = IDLE.
  - All outputs 0; `mem_raddr`, `mem_waddr` and `mem_wdata` are also 0.
- Tick counter:
  - Counts from 0 to `REF_PERIOD`-1 and wraps.
  - At the wrap it sets `pending`.
  - If `pending` is already 1 at the wrap, it sets `ref_overrun`. The flag clears only on reset.
- FSM states: IDLE, WAIT, READ, LAT, WRITE, DONE.
  - IDLE → WAIT when `pending` is set.
  - WAIT → READ when `user_req`=0 (or when urgent; see Configuration). Entering READ clears `pending`.
  - READ, one cycle: `mem_re`=1 and `mem_raddr` = shadow[`swap_idx`]. Then LAT.
  - LAT, `MEM_LAT` cycles: `mem_rdata` is captured on the last LAT cycle. Then WRITE.
  - WRITE, one cycle: `mem_we`=1, `mem_waddr` = shadow[0], `mem_wdata` = captured data. Then DONE.
  - DONE, one cycle: `any_ref_done`=1; shadow[0] and shadow[`swap_idx`] are exchanged; `swap_idx` becomes 7 if it was 1, otherwise `swap_idx`−1. Then WAIT if `pending`, else IDLE.
- `ref_busy`=1 in READ, LAT, WRITE and DONE. `user_req` is ignored in those states; a user must not touch the array while `ref_busy`=1.
- Simultaneous events:
  - A tick on the same cycle as the WAIT → READ transition: `pending` ends at 1 (set wins over clear) and there is no overrun.
  - A tick during DONE: normal set; the FSM goes to WAIT.
- A reset taken mid-sequence aborts it with no `any_ref_done` pulse, so the shadow table and the address table stay aligned (both reset).

## Timing
- A tick lands on the clock edge where the counter wraps.
- Minimum tick-to-`any_ref_done` latency with no user traffic is 4+`MEM_LAT` cycles: IDLE→WAIT, WAIT→READ, READ, LAT×`MEM_LAT`, WRITE, then DONE.
- Strobes are registered FSM decodes, so they change only on clock edges.
- `any_ref_done` is high exactly one cycle per completed copy. The shadow update becomes visible the cycle after DONE, the same edge on which the address table swaps.

## Configuration
- `REF_URGENT_EN` defined:
  - A wait counter increments each cycle in WAIT and clears on leaving WAIT.
  - When it reaches `URGENT_LIM`, `user_stall`=1 and WAIT → READ regardless of `user_req`.
  - `user_stall` also stays high through READ to DONE of that urgent sequence.
- `REF_URGENT_EN` undefined: `user_stall` is constant 0, there is no wait counter, and WAIT leaves only when `user_req`=0.

## Test plan
- Reset, then idle with `user_req`=0, `MEM_LAT`=1, `REF_PERIOD`=64 → `mem_re` at cycle 65 with `mem_raddr`=0. `mem_we` at 67 with `mem_waddr`=1. `any_ref_done` at 68. Shadow becomes {0,1,2,…}; `swap_idx`=7.
- Eight consecutive refreshes with no user traffic → read rows follow the shadow mapping; `swap_idx` walks 1,7,6,5,4,3,2,1. The shadow table must match an address-table model after every `any_ref_done`.
- `mem_rdata`=8'hA5 at the capture cycle with `MEM_LAT`=3 → `mem_wdata`=8'hA5 during WRITE; `mem_we` 4 cycles after `mem_re`.
- `user_req` held at 1 for 100 cycles, macro undefined → FSM stays in WAIT, `ref_overrun`=1 after the next tick, and no `any_ref_done` until `user_req` drops.
- Same stimulus with `REF_URGENT_EN` defined and `URGENT_LIM`=16 → `user_stall` rises 16 cycles after entering WAIT; copy completes; `ref_overrun` stays 0.
- `rst`=0 asserted during LAT → no `any_ref_done`; all outputs 0 the next cycle; shadow reset; a later tick reads row 0 again.
